// File: rtl/intersection_phase_scheduler_if.sv
// Request/lamp bundle for the intersection phase scheduler.
//   ns_req, ew_req : vehicle detector pulses or levels
//   ped_req        : pedestrian button
//   emg_req        : emergency pre-empt (level)
//   emg_dir        : emergency direction, 0=NS 1=EW
//   north_south    : NS lamps, one-hot {green,yellow,red}
//   east_west      : EW lamps, one-hot {green,yellow,red}
//   walk           : pedestrian walk lamp
//   phase          : current controller state code
// master drives requests and observes lamps; slave is the controller.
interface intersection_phase_scheduler_if;
  logic       ns_req;
  logic       ew_req;
  logic       ped_req;
  logic       emg_req;
  logic       emg_dir;
  logic [2:0] north_south;
  logic [2:0] east_west;
  logic       walk;
  logic [2:0] phase;

  modport master (
    output ns_req, ew_req, ped_req, emg_req, emg_dir,
    input  north_south, east_west, walk, phase
  );

  modport slave (
    input  ns_req, ew_req, ped_req, emg_req, emg_dir,
    output north_south, east_west, walk, phase
  );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Two-way intersection phase scheduler with pedestrian phase and
// emergency pre-emption. All timing is in one-second ticks derived from
// a TICK_DIV-cycle prescaler; prescaler and second counter restart on
// every state change.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : request inputs / lamp + phase outputs (slave modport)
module intersection_phase_scheduler #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned MIN_GREEN = 10,
  parameter int unsigned MAX_GREEN = 60,
  parameter int unsigned YELLOW_T  = 4,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned PED_T     = 8
) (
  input logic                          clk,
  input logic                          rst,
  intersection_phase_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    ALL_RED = 3'd0,
    NS_G    = 3'd1,
    NS_Y    = 3'd2,
    EW_G    = 3'd3,
    EW_Y    = 3'd4,
    PED     = 3'd5,
    EMG     = 3'd6
  } state_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned TMAX = max2(max2(max2(MIN_GREEN, MAX_GREEN), max2(YELLOW_T, ALLRED_T)), PED_T);
  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW   = $clog2(TMAX + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SEC_SAT  = SW'(TMAX);

  // True on the tick that completes t seconds, or any time after it.
  function automatic logic elapsed(input logic [SW-1:0] s, input logic tk, input int unsigned t);
    logic [31:0] s32;
    s32 = 32'(s);
    return (s32 >= t) || (tk && ((s32 + 32'd1) == t));
  endfunction

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          ns_pend_q, ns_pend_d;
  logic          ew_pend_q, ew_pend_d;
  logic          ped_pend_q, ped_pend_d;
  logic          last_ew_q, last_ew_d;   // 1: EW was served last
  logic          emg_dir_q, emg_dir_d;
  logic [2:0]    ns_lamp_q, ns_lamp_d;
  logic [2:0]    ew_lamp_q, ew_lamp_d;
  logic          walk_q, walk_d;

  logic tick;
  logic min_el, max_el;
  logic ns_conflict, ew_conflict;

  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    state_d     = state_q;
    emg_dir_d   = emg_dir_q;
    min_el      = elapsed(sec_q, tick, MIN_GREEN);
    max_el      = elapsed(sec_q, tick, MAX_GREEN);
    ns_conflict = ew_pend_q | ped_pend_q;
    ew_conflict = ns_pend_q | ped_pend_q;

    case (state_q)
      ALL_RED: begin
        if (elapsed(sec_q, tick, ALLRED_T)) begin
          if (bus.emg_req) begin
            state_d   = EMG;
            emg_dir_d = bus.emg_dir;
          end else if (ped_pend_q) begin
            state_d = PED;
          end else if (last_ew_q) begin
            // Opposite direction unless only the same direction is waiting.
            state_d = (ew_pend_q && !ns_pend_q) ? EW_G : NS_G;
          end else begin
            state_d = (ns_pend_q && !ew_pend_q) ? NS_G : EW_G;
          end
        end
      end
      NS_G: begin
        if (bus.emg_req) begin
          if (bus.emg_dir) begin
            state_d = NS_Y;
          end else begin
            state_d   = EMG;
            emg_dir_d = 1'b0;
          end
        end else if (ns_conflict && (max_el || (min_el && !ns_pend_q))) begin
          // Own-direction demand extends green up to MAX_GREEN.
          state_d = NS_Y;
        end
      end
      EW_G: begin
        if (bus.emg_req) begin
          if (!bus.emg_dir) begin
            state_d = EW_Y;
          end else begin
            state_d   = EMG;
            emg_dir_d = 1'b1;
          end
        end else if (ew_conflict && (max_el || (min_el && !ew_pend_q))) begin
          state_d = EW_Y;
        end
      end
      NS_Y, EW_Y: begin
        if (elapsed(sec_q, tick, YELLOW_T)) state_d = ALL_RED;
      end
      PED: begin
        if (bus.emg_req || elapsed(sec_q, tick, PED_T)) state_d = ALL_RED;
      end
      EMG: begin
        if (!bus.emg_req) state_d = emg_dir_q ? EW_Y : NS_Y;
      end
      default: state_d = ALL_RED;
    endcase
  end

  always_comb begin
    if (state_d != state_q) begin
      pre_d = '0;
      sec_d = '0;
    end else begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      sec_d = (tick && (sec_q != SEC_SAT)) ? sec_q + 1'b1 : sec_q;
    end

    // A request seen on the entry edge itself is dropped with the flag.
    ns_pend_d  = (ns_pend_q  | bus.ns_req)  & ~((state_d == NS_G) && (state_q != NS_G));
    ew_pend_d  = (ew_pend_q  | bus.ew_req)  & ~((state_d == EW_G) && (state_q != EW_G));
    ped_pend_d = (ped_pend_q | bus.ped_req) & ~((state_d == PED)  && (state_q != PED));

    last_ew_d = last_ew_q;
    if ((state_d == NS_G) && (state_q != NS_G)) last_ew_d = 1'b0;
    if ((state_d == EW_G) && (state_q != EW_G)) last_ew_d = 1'b1;
  end

  // Lamps are registered from the next state so they switch with the state flop.
  always_comb begin
    ns_lamp_d = 3'b001;
    ew_lamp_d = 3'b001;
    walk_d    = 1'b0;
    case (state_d)
      NS_G: ns_lamp_d = 3'b100;
      NS_Y: ns_lamp_d = 3'b010;
      EW_G: ew_lamp_d = 3'b100;
      EW_Y: ew_lamp_d = 3'b010;
      PED:  walk_d    = 1'b1;
      EMG: begin
        if (emg_dir_d) ew_lamp_d = 3'b100;
        else           ns_lamp_d = 3'b100;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ALL_RED;
      pre_q      <= '0;
      sec_q      <= '0;
      ns_pend_q  <= 1'b0;
      ew_pend_q  <= 1'b0;
      ped_pend_q <= 1'b0;
      last_ew_q  <= 1'b1;
      emg_dir_q  <= 1'b0;
      ns_lamp_q  <= 3'b001;
      ew_lamp_q  <= 3'b001;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      sec_q      <= sec_d;
      ns_pend_q  <= ns_pend_d;
      ew_pend_q  <= ew_pend_d;
      ped_pend_q <= ped_pend_d;
      last_ew_q  <= last_ew_d;
      emg_dir_q  <= emg_dir_d;
      ns_lamp_q  <= ns_lamp_d;
      ew_lamp_q  <= ew_lamp_d;
      walk_q     <= walk_d;
    end
  end

  assign bus.north_south = ns_lamp_q;
  assign bus.east_west   = ew_lamp_q;
  assign bus.walk        = walk_q;
  assign bus.phase       = state_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with short timing
// (TICK_DIV=4, MIN=3, MAX=6, YEL=2, AR=1, PED=2 seconds).
module tb_intersection_phase_scheduler;
  localparam logic [2:0] P_AR  = 3'd0, P_NSG = 3'd1, P_NSY = 3'd2, P_EWG = 3'd3,
                         P_EWY = 3'd4, P_PED = 3'd5, P_EMG = 3'd6;
  localparam logic [2:0] L_G = 3'b100, L_Y = 3'b010, L_R = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  intersection_phase_scheduler_if bus ();

  intersection_phase_scheduler #(
    .TICK_DIV (4),
    .MIN_GREEN(3),
    .MAX_GREEN(6),
    .YELLOW_T (2),
    .ALLRED_T (1),
    .PED_T    (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Check phase/lamps at the current sample; if len>0, count samples spent
  // in this phase (including the current one) and check the count.
  task automatic expect_state(input string tag, input logic [2:0] ph, input logic [2:0] ns,
                              input logic [2:0] ew, input logic wk, input int len);
    int n;
    check({tag, "_phase"}, bus.phase, ph);
    check({tag, "_ns"}, bus.north_south, ns);
    check({tag, "_ew"}, bus.east_west, ew);
    check({tag, "_walk"}, bus.walk, wk);
    if (len > 0) begin
      n = 0;
      while (bus.phase == ph && n < 200) begin
        n++;
        @(negedge clk);
      end
      check({tag, "_len"}, n, len);
    end
  endtask

  task automatic wait_phase(input string tag, input logic [2:0] ph, input int budget);
    int n;
    n = 0;
    while (bus.phase != ph && n < budget) begin
      n++;
      @(negedge clk);
    end
    check(tag, bus.phase, ph);
  endtask

  initial begin
    bus.ns_req  = 1'b0;
    bus.ew_req  = 1'b0;
    bus.ped_req = 1'b0;
    bus.emg_req = 1'b0;
    bus.emg_dir = 1'b0;

    // Reset state, then first grant to NS after a full all-red.
    repeat (3) @(negedge clk);
    expect_state("rst", P_AR, L_R, L_R, 1'b0, 0);
    rst = 1'b0;
    expect_state("ar0", P_AR, L_R, L_R, 1'b0, 4);

    // EW pulse at NS_G cycle 1: green ends at MIN_GREEN.
    bus.ew_req = 1'b1;
    @(negedge clk);
    bus.ew_req = 1'b0;
    expect_state("nsg1", P_NSG, L_G, L_R, 1'b0, 11);
    expect_state("nsy1", P_NSY, L_Y, L_R, 1'b0, 8);
    expect_state("ar1",  P_AR,  L_R, L_R, 1'b0, 4);
    expect_state("ewg1", P_EWG, L_R, L_G, 1'b0, 0);
    repeat (40) @(negedge clk);
    check("ewg1_rest", bus.phase, P_EWG);

    // Pedestrian pulse while resting in EW_G.
    bus.ped_req = 1'b1;
    @(negedge clk);
    bus.ped_req = 1'b0;
    wait_phase("ewy2_wait", P_EWY, 10);
    expect_state("ewy2", P_EWY, L_R, L_Y, 1'b0, 8);
    expect_state("ar2",  P_AR,  L_R, L_R, 1'b0, 4);
    expect_state("ped2", P_PED, L_R, L_R, 1'b1, 8);
    expect_state("ar3",  P_AR,  L_R, L_R, 1'b0, 4);

    // Continuous demand on both: greens run to MAX_GREEN and alternate.
    bus.ns_req = 1'b1;
    bus.ew_req = 1'b1;
    expect_state("nsg3", P_NSG, L_G, L_R, 1'b0, 24);
    expect_state("nsy3", P_NSY, L_Y, L_R, 1'b0, 8);
    expect_state("ar4",  P_AR,  L_R, L_R, 1'b0, 4);
    expect_state("ewg3", P_EWG, L_R, L_G, 1'b0, 24);
    expect_state("ewy3", P_EWY, L_R, L_Y, 1'b0, 8);
    expect_state("ar5",  P_AR,  L_R, L_R, 1'b0, 4);
    // Drop demand at NS_G entry: only EW remains pending, so MIN_GREEN.
    bus.ns_req = 1'b0;
    bus.ew_req = 1'b0;
    expect_state("nsg4", P_NSG, L_G, L_R, 1'b0, 12);
    expect_state("nsy4", P_NSY, L_Y, L_R, 1'b0, 8);
    expect_state("ar6",  P_AR,  L_R, L_R, 1'b0, 4);

    // Emergency for the direction already green: EMG on the next edge.
    expect_state("ewg5", P_EWG, L_R, L_G, 1'b0, 0);
    bus.emg_req = 1'b1;
    bus.emg_dir = 1'b1;
    @(negedge clk);
    expect_state("emg5", P_EMG, L_R, L_G, 1'b0, 0);
    bus.emg_req = 1'b0;
    @(negedge clk);
    expect_state("ewy5", P_EWY, L_R, L_Y, 1'b0, 8);
    expect_state("ar7",  P_AR,  L_R, L_R, 1'b0, 4);

    // Emergency EW at NS_G cycle 2: immediate yellow, then EMG.
    expect_state("nsg6", P_NSG, L_G, L_R, 1'b0, 0);
    repeat (2) @(negedge clk);
    bus.emg_req = 1'b1;
    bus.emg_dir = 1'b1;
    expect_state("nsg6b", P_NSG, L_G, L_R, 1'b0, 1);
    expect_state("nsy6",  P_NSY, L_Y, L_R, 1'b0, 8);
    expect_state("ar8",   P_AR,  L_R, L_R, 1'b0, 4);
    expect_state("emg6",  P_EMG, L_R, L_G, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) bus.emg_dir = 1'b0;
      @(negedge clk);
    end
    expect_state("emg6_hold", P_EMG, L_R, L_G, 1'b0, 0);
    bus.emg_req = 1'b0;
    @(negedge clk);
    expect_state("ewy6", P_EWY, L_R, L_Y, 1'b0, 0);

    // Asynchronous reset mid-yellow, then a full restart.
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    expect_state("arst", P_AR, L_R, L_R, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;
    expect_state("ar9",  P_AR,  L_R, L_R, 1'b0, 4);
    expect_state("nsg9", P_NSG, L_G, L_R, 1'b0, 0);
    repeat (40) @(negedge clk);
    check("nsg9_rest", bus.phase, P_NSG);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
